// File: rtl/lcd_ctrl_gen2_pkg.sv
// Shared types and window helpers for the gen2 LCD image controller.
// Commands, FSM states and window index math live here.
package lcd_ctrl_gen2_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE  = 4'd0,
    CMD_UP     = 4'd1,
    CMD_DOWN   = 4'd2,
    CMD_LEFT   = 4'd3,
    CMD_RIGHT  = 4'd4,
    CMD_MAX    = 4'd5,
    CMD_MIN    = 4'd6,
    CMD_AVG    = 4'd7,
    CMD_ROTL   = 4'd8,
    CMD_ROTR   = 4'd9,
    CMD_MIRX   = 4'd10,
    CMD_MIRY   = 4'd11,
    CMD_RELOAD = 4'd12
  } cmd_e;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_IDLE,
    ST_EXEC,
    ST_REDUCE,
    ST_APPLY,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Reduce modes match the low bits of CMD_MAX/MIN/AVG
  localparam logic [1:0] RED_MAX = 2'd1;
  localparam logic [1:0] RED_MIN = 2'd2;
  localparam logic [1:0] RED_AVG = 2'd3;

  function automatic int win_row(int op, int idx, int win);
    return op - win / 2 + idx / win;
  endfunction

  function automatic int win_col(int op, int idx, int win);
    return op - win / 2 + idx % win;
  endfunction

endpackage

// File: rtl/lcd_ctrl_gen2_reduce.sv
// Streaming max/min/sum over a window scan.
// The first enabled pixel after a clear seeds the accumulator.
module lcd_win_reduce
  import lcd_ctrl_gen2_pkg::*;
#(
  parameter int DW = 8,
  parameter int WL = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [1:0]    mode_i,
  input  logic [DW-1:0] pix_i,
  output logic [DW-1:0] res_o
);

  localparam int AC = DW + 2 * WL;

  logic [AC-1:0] acc_q, acc_d, px;
  logic          first_q;

  assign px = {{(2 * WL){1'b0}}, pix_i};

  always_comb begin
    acc_d = acc_q;
    unique case (mode_i)
      RED_MAX: if (first_q || px > acc_q) acc_d = px;
      RED_MIN: if (first_q || px < acc_q) acc_d = px;
      RED_AVG: acc_d = first_q ? px : acc_q + px;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      first_q <= 1'b0;
    end else if (clr_i) begin
      acc_q   <= '0;
      first_q <= 1'b1;
    end else if (en_i) begin
      acc_q   <= acc_d;
      first_q <= 1'b0;
    end
  end

  // Average is a floor divide by WIN^2, i.e. drop 2*WL bits
  assign res_o = (mode_i == RED_AVG) ? acc_q[2*WL +: DW]
                                     : acc_q[DW-1:0];

endmodule

// File: rtl/lcd_ctrl_gen2.sv
// Parametrised LCD image controller: IROM load, window ops, IRAM dump.
// Holds the FSM, op point, pixel buffer and address counters.
module lcd_ctrl_gen2
  import lcd_ctrl_gen2_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int DW    = 8,
  parameter int WIN   = 4,
  localparam int AW   = $clog2(IMG_W * IMG_W),
  localparam int PW   = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  input  logic [DW-1:0] IROM_Q,
  output logic          IRAM_valid,
  output logic [AW-1:0] IRAM_A,
  output logic [DW-1:0] IRAM_D,
  output logic          busy,
  output logic          done
);

  localparam int N  = IMG_W * IMG_W;
  localparam int WN = WIN * WIN;
  localparam int HW = WIN / 2;
  localparam int WL = $clog2(WIN);
  localparam int CW = AW + 1;

  state_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [PW-1:0] x_q, x_d, y_q, y_d;
  logic          rd_q, rd_d, wv_q, wv_d;
  logic [AW-1:0] ra_q, ra_d, wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          red_clr, red_en;
  logic [DW-1:0] red_pix, red_res;
  logic [DW-1:0] pix_q [N];

  function automatic logic [AW-1:0] waddr(int xo, int yo, int i);
    return AW'(win_row(yo, i, WIN) * IMG_W + win_col(xo, i, WIN));
  endfunction

  assign red_pix = pix_q[waddr(int'(x_q), int'(y_q), int'(cnt_q))];

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    x_d     = x_q;
    y_d     = y_q;
    rd_d    = 1'b0;
    ra_d    = ra_q;
    wv_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    red_clr = 1'b0;
    red_en  = 1'b0;
    unique case (st_q)
      ST_LOAD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N)) begin
          st_d   = ST_IDLE;
          busy_d = 1'b0;
        end else begin
          rd_d = 1'b1;
          ra_d = cnt_q[AW-1:0];
        end
      end
      ST_IDLE: if (cmd_valid && !busy_q) begin
        busy_d = 1'b1;
        cmd_d  = cmd;
        cnt_d  = '0;
        case (cmd)
          CMD_WRITE: begin
            st_d  = ST_WRITE;
            wv_d  = 1'b1;
            wa_d  = '0;
            wd_d  = pix_q[0];
            cnt_d = CW'(1);
          end
          CMD_MAX, CMD_MIN, CMD_AVG: begin
            st_d    = ST_REDUCE;
            red_clr = 1'b1;
          end
          CMD_RELOAD: st_d = ST_LOAD;
          default:    st_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        st_d   = ST_IDLE;
        busy_d = 1'b0;
        case (cmd_q)
          CMD_UP:    if (y_q > PW'(HW)) y_d = y_q - PW'(1);
          CMD_DOWN:  if (y_q < PW'(IMG_W - HW)) y_d = y_q + PW'(1);
          CMD_LEFT:  if (x_q > PW'(HW)) x_d = x_q - PW'(1);
          CMD_RIGHT: if (x_q < PW'(IMG_W - HW)) x_d = x_q + PW'(1);
          default: ;
        endcase
      end
      ST_REDUCE: begin
        red_en = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WN - 1)) st_d = ST_APPLY;
      end
      ST_APPLY: begin
        st_d   = ST_IDLE;
        busy_d = 1'b0;
      end
      ST_WRITE: begin
        if (cnt_q == CW'(N)) begin
          st_d   = ST_DONE;
          done_d = 1'b1;
        end else begin
          wv_d  = 1'b1;
          wa_d  = cnt_q[AW-1:0];
          wd_d  = pix_q[cnt_q[AW-1:0]];
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        st_d   = ST_IDLE;
        busy_d = 1'b0;
      end
      default: st_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= ST_LOAD;
      cnt_q  <= '0;
      cmd_q  <= '0;
      x_q    <= PW'(IMG_W / 2);
      y_q    <= PW'(IMG_W / 2);
      rd_q   <= 1'b0;
      ra_q   <= '0;
      wv_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      cmd_q  <= cmd_d;
      x_q    <= x_d;
      y_q    <= y_d;
      rd_q   <= rd_d;
      ra_q   <= ra_d;
      wv_q   <= wv_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Buffer has no reset: contents are reloaded after every reset
  always_ff @(posedge clk) begin
    if (st_q == ST_LOAD && cnt_q != '0)
      pix_q[AW'(cnt_q - CW'(1))] <= IROM_Q;
    if (st_q == ST_APPLY)
      for (int i = 0; i < WN; i++)
        pix_q[waddr(int'(x_q), int'(y_q), i)] <= red_res;
    if (st_q == ST_EXEC)
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++)
          case (cmd_q)
            CMD_ROTL: pix_q[waddr(int'(x_q), int'(y_q), r * WIN + c)] <=
              pix_q[waddr(int'(x_q), int'(y_q), c * WIN + WIN - 1 - r)];
            CMD_ROTR: pix_q[waddr(int'(x_q), int'(y_q), r * WIN + c)] <=
              pix_q[waddr(int'(x_q), int'(y_q), (WIN - 1 - c) * WIN + r)];
            CMD_MIRX: pix_q[waddr(int'(x_q), int'(y_q), r * WIN + c)] <=
              pix_q[waddr(int'(x_q), int'(y_q), (WIN - 1 - r) * WIN + c)];
            CMD_MIRY: pix_q[waddr(int'(x_q), int'(y_q), r * WIN + c)] <=
              pix_q[waddr(int'(x_q), int'(y_q), r * WIN + WIN - 1 - c)];
            default: ;
          endcase
  end

  lcd_win_reduce #(
    .DW (DW),
    .WL (WL)
  ) u_reduce (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (red_clr),
    .en_i   (red_en),
    .mode_i (cmd_q[1:0]),
    .pix_i  (red_pix),
    .res_o  (red_res)
  );

  assign IROM_rd    = rd_q;
  assign IROM_A     = ra_q;
  assign IRAM_valid = wv_q;
  assign IRAM_A     = wa_q;
  assign IRAM_D     = wd_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lcd_ctrl_gen2.sv
// Bench for lcd_ctrl_gen2: IROM/IRAM models plus a pixel-grid reference.
// Directed spec scenarios followed by randomized command streams.
module tb_lcd_ctrl_gen2;

  localparam int IW  = 8;
  localparam int N   = IW * IW;
  localparam int WIN = 4;
  localparam int HW  = WIN / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cmd = '0;
  logic       cmd_valid = 1'b0;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q = '0;
  logic       IRAM_valid;
  logic [5:0] IRAM_A;
  logic [7:0] IRAM_D;
  logic       busy;
  logic       done;

  logic [7:0] rom  [N];
  logic [7:0] iram [N];
  int mdl [IW][IW];
  int ox, oy;
  int total = 0;
  int bad = 0;
  int done_cnt;
  bit done_pos_ok;

  lcd_ctrl_gen2 dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .IROM_rd    (IROM_rd),
    .IROM_A     (IROM_A),
    .IROM_Q     (IROM_Q),
    .IRAM_valid (IRAM_valid),
    .IRAM_A     (IRAM_A),
    .IRAM_D     (IRAM_D),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (IROM_rd) IROM_Q <= rom[IROM_A];

  function automatic void mdl_load();
    for (int i = 0; i < N; i++) mdl[i / IW][i % IW] = rom[i];
  endfunction

  task automatic model_cmd(input int cv);
    int w [WIN][WIN];
    int v [WIN][WIN];
    int acc;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) begin
        w[r][c] = mdl[oy - HW + r][ox - HW + c];
        v[r][c] = w[r][c];
      end
    case (cv)
      1: if (oy > HW) oy--;
      2: if (oy < IW - HW) oy++;
      3: if (ox > HW) ox--;
      4: if (ox < IW - HW) ox++;
      5, 6, 7: begin
        acc = (cv == 6) ? 255 : 0;
        for (int r = 0; r < WIN; r++)
          for (int c = 0; c < WIN; c++)
            if (cv == 5 && w[r][c] > acc) acc = w[r][c];
            else if (cv == 6 && w[r][c] < acc) acc = w[r][c];
            else if (cv == 7) acc += w[r][c];
        if (cv == 7) acc = acc / (WIN * WIN);
        for (int r = 0; r < WIN; r++)
          for (int c = 0; c < WIN; c++) v[r][c] = acc;
      end
      8, 9, 10, 11:
        for (int r = 0; r < WIN; r++)
          for (int c = 0; c < WIN; c++)
            case (cv)
              8:  v[r][c] = w[c][WIN - 1 - r];
              9:  v[r][c] = w[WIN - 1 - c][r];
              10: v[r][c] = w[WIN - 1 - r][c];
              default: v[r][c] = w[r][WIN - 1 - c];
            endcase
      12: mdl_load();
      default: ;
    endcase
    if (cv >= 5 && cv <= 11)
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++)
          mdl[oy - HW + r][ox - HW + c] = v[r][c];
  endtask

  task automatic run_cmd(input logic [3:0] c, output int cyc);
    logic       pv;
    logic [5:0] pa;
    @(negedge clk);
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cyc = 1;
    done_cnt = 0;
    done_pos_ok = 1'b0;
    pv = 1'b0;
    pa = '0;
    while (busy && cyc < 400) begin
      if (IRAM_valid) iram[IRAM_A] = IRAM_D;
      if (done) begin
        done_cnt++;
        done_pos_ok = pv && (pa == 6'(N - 1));
      end
      pv = IRAM_valid;
      pa = IRAM_A;
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL cmd_timeout cmd=%0d busy=%b after %0d cycles, need 0",
               c, busy, cyc);
    end
    model_cmd(int'(c));
  endtask

  task automatic check_image(input string nm);
    int cyc;
    for (int i = 0; i < N; i++) iram[i] = 8'hxx;
    run_cmd(4'd0, cyc);
    for (int i = 0; i < N; i++) begin
      total++;
      if (iram[i] !== 8'(mdl[i / IW][i % IW])) begin
        bad++;
        $display("FAIL %s pix[%0d] got %0d need %0d",
                 nm, i, iram[i], mdl[i / IW][i % IW]);
      end
    end
    total++;
    if (done_cnt !== 1 || done_pos_ok !== 1'b1) begin
      bad++;
      $display("FAIL %s done pulses=%0d after_last=%0b need 1/1",
               nm, done_cnt, done_pos_ok);
    end
  endtask

  task automatic check_px(input string nm, input int idx, input int exp);
    total++;
    if (iram[idx] !== 8'(exp)) begin
      bad++;
      $display("FAIL %s pix[%0d] got %0d need %0d", nm, idx, iram[idx], exp);
    end
  endtask

  task automatic release_and_load(input string nm);
    int  cyc;
    int  k;
    bit  seq_ok;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    k = 0;
    seq_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (IROM_rd) begin
        if (IROM_A !== 6'(k)) seq_ok = 1'b0;
        k++;
      end
    end while (busy && cyc < 200);
    total++;
    if (cyc != N + 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s load_cycles got %0d need %0d", nm, cyc, N + 1);
    end
    total++;
    if (!seq_ok || k != N) begin
      bad++;
      $display("FAIL %s irom_seq reads=%0d inorder=%0b need %0d/1",
               nm, k, seq_ok, N);
    end
    ox = IW / 2;
    oy = IW / 2;
    mdl_load();
  endtask

  task automatic test_reset();
    logic [24:0] got;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    got = {IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, busy, done};
    total++;
    if (got !== {1'b0, 6'd0, 1'b0, 6'd0, 8'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs got %h need %h", got,
               {1'b0, 6'd0, 1'b0, 6'd0, 8'd0, 1'b1, 1'b0});
    end
    release_and_load("reset");
  endtask

  task automatic test_write();
    check_image("write_identity");
  endtask

  task automatic test_reduce();
    int cyc;
    run_cmd(4'd5, cyc);
    check_image("max");
    check_px("max_win", 3 * IW + 3, 45);
    check_px("max_out", 1 * IW + 1, 9);
    run_cmd(4'd12, cyc);
    run_cmd(4'd6, cyc);
    check_image("min");
    check_px("min_win", 5 * IW + 5, 18);
    run_cmd(4'd12, cyc);
    run_cmd(4'd7, cyc);
    check_image("avg");
    check_px("avg_win", 2 * IW + 2, 31);
  endtask

  task automatic test_shift();
    int cyc;
    run_cmd(4'd12, cyc);
    repeat (3) run_cmd(4'd1, cyc);
    run_cmd(4'd5, cyc);
    check_image("shift_up");
    check_px("up_clamp", 0 * IW + 2, 29);
    check_px("up_below", 4 * IW + 2, 34);
    run_cmd(4'd12, cyc);
    repeat (5) run_cmd(4'd4, cyc);
    run_cmd(4'd5, cyc);
    check_image("shift_right");
    check_px("right_clamp", 0 * IW + 7, 31);
    check_px("right_left", 0 * IW + 3, 3);
  endtask

  task automatic test_rotmir();
    int cyc;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    release_and_load("rot_reset");
    run_cmd(4'd9, cyc);
    run_cmd(4'd11, cyc);
    check_image("rot_mir");
    check_px("transpose_a", 2 * IW + 3, 26);
    check_px("transpose_b", 3 * IW + 2, 19);
    run_cmd(4'd8, cyc);
    run_cmd(4'd10, cyc);
    check_image("rotl_mirx");
  endtask

  task automatic test_busy();
    int cyc;
    int n;
    run_cmd(4'd12, cyc);
    @(negedge clk);
    cmd = 4'd5;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd = 4'd12;
    repeat (8) @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_wait busy=%b need 0", busy);
    end
    model_cmd(5);
    check_image("busy_ignore");
    run_cmd(4'd13, cyc);
    total++;
    if (cyc != 2) begin
      bad++;
      $display("FAIL noop_busy cycles got %0d need 2", cyc);
    end
    run_cmd(4'd2, cyc);
    total++;
    if (cyc != 2) begin
      bad++;
      $display("FAIL shift_busy cycles got %0d need 2", cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < N; i++) rom[i] = 8'($urandom);
      run_cmd(4'd12, cyc);
      for (int k = 0; k < 25; k++)
        run_cmd(4'($urandom_range(1, 15)), cyc);
      check_image("random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (IRAM_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset valid=%b busy=%b done=%b need 0/1/0",
               IRAM_valid, busy, done);
    end
    @(negedge clk);
    release_and_load("mid_reset");
    check_image("after_mid_reset");
  endtask

  initial begin
    for (int i = 0; i < N; i++) rom[i] = 8'(i);
    test_reset();
    test_write();
    test_reduce();
    test_shift();
    test_rotmir();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
